word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-in, serial-out converter feeding the serial pattern detector's `d` input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock.
- Holds one additional word in a holding register, so back-to-back words stream without gaps.
- Drives IDLE_BIT when no word is in flight; the downstream Moore detector sees a defined bit every cycle.

Parameters:
- WIDTH, 8, word width in bits (>= 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- IDLE_BIT, 0, value driven on d_out while idle.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- d_out  output  1  serial bit stream, connects to detector d.
- bit_valid  output  1  d_out carries a word bit (not idle fill).
- word_start  output  1  high during the first bit of each word.
- busy  output  1  shifter or holding register occupied.

Behaviour:
- Clocking/reset:
  - One clock; reset is synchronous and active-high.
  - On a reset edge: state = IDLE, bit counter = 0, shifter cleared, hold_full = 0.
  - After reset: d_out = IDLE_BIT, bit_valid = 0, word_start = 0, busy = 0, in_ready = 1.
  - While reset is asserted, in_ready is forced 0.
- Handshake:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - in_ready = !hold_full & !reset.
  - in_data must be held stable while in_valid is high and in_ready is low.
- State machine (states IDLE, SHIFT), evaluated at each rising edge:
  - IDLE + transfer -> load in_data into shifter, cnt = 0, go to SHIFT.
  - IDLE, no transfer -> stay IDLE.
  - SHIFT, cnt < WIDTH-1 -> advance shifter one bit, cnt++.
    - A transfer in this cycle writes the holding register and sets hold_full.
  - SHIFT, cnt == WIDTH-1 (last bit on d_out), pick the first that applies:
    - If hold_full: load hold into shifter, clear hold_full, cnt = 0, stay SHIFT.
    - Else if transfer: load in_data directly into shifter, cnt = 0, stay SHIFT.
    - Else: go to IDLE.
- Outputs (derived from registered state only, no input-to-output path except in_ready):
  - d_out = current shifter bit in SHIFT; IDLE_BIT in IDLE.
  - bit_valid = (state == SHIFT).
  - word_start = SHIFT & cnt == 0.
  - busy = SHIFT | hold_full.
- Latency and throughput:
  - Transfer at edge N with the shifter empty -> first bit on d_out in the cycle after edge N.
  - Continuous in_valid sustains one word per WIDTH cycles with zero idle bits between words.
- Boundary conditions:
  - hold_full and a transfer cannot coincide, because in_ready = 0 while hold_full.
  - A transfer on the last-bit edge with hold empty bypasses the hold register.
  - Counter width is clog2(WIDTH); it wraps only via explicit reload to 0.
  - Reset mid-word discards both the shifter and the hold contents; d_out returns to IDLE_BIT after that edge, and no partial word resumes.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum {IDLE, SHIFT};
  - default IDLE_BIT;
  - the pattern constant 4'b1001 used by the detector and by benches.
- No sub-module; the bit counter and holding register are inline. The serializer and detector are instantiated side by side at the serial-path top level.

Test Plan:
- Reset then idle 20 cycles -> d_out = 0, bit_valid = 0, in_ready = 1, busy = 0 throughout.
- Single word 0x96, WIDTH = 8, MSB_FIRST = 1, transfer at edge N -> d_out = 1,0,0,1,0,1,1,0 over cycles N+1..N+8, word_start only at N+1, then idle. The detector q pulses after the 4th bit.
- Back-to-back 0xA5, 0x3C, 0xFF with in_valid held high -> 24 contiguous valid bits, no gap. in_ready drops the cycle after the second transfer and rises after each hold reload.
- MSB_FIRST = 0, word 0x01 -> d_out = 1,0,0,0,0,0,0,0.
- Transfer exactly on the last-bit edge with hold empty -> next word's first bit immediately follows the previous last bit, with no idle cycle.
- Reset asserted at bit 3 of 0x96 with hold_full -> after the edge, d_out = 0, bit_valid = 0, hold cleared. A new word 0x80 then streams 1,0,0,0,0,0,0,0 correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial path (serializer, pattern detector, benches).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Sequence the downstream Moore detector fires on.
  localparam logic [3:0] DETECT_PATTERN = 4'b1001;

endpackage

// File: rtl/word_serializer.sv
// Parallel-in, serial-out converter with a one-word holding register so that
// consecutive words stream with no idle bits in between.
module word_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             xfer;
  logic             cur_bit;
  logic [WIDTH-1:0] shift_adv;

  assign in_ready = !hold_full_q && !reset;
  assign xfer     = in_valid && in_ready;

  // The outgoing bit always sits at one end of the shifter; advancing moves the next one there.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit   = shift_q[WIDTH-1];
      assign shift_adv = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit   = shift_q[0];
      assign shift_adv = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + CW'(1);
          if (xfer) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // A held word has priority; in_ready is low so no transfer can collide with it.
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (xfer) begin
          shift_d = in_data;
          cnt_d   = '0;
        end else begin
          shift_d = shift_adv;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bit_valid  = (state_q == SHIFT);
  assign d_out      = bit_valid ? cur_bit : IDLE_BIT;
  assign word_start = bit_valid && (cnt_q == '0);
  assign busy       = bit_valid || hold_full_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one MSB-first and one LSB-first instance.
module tb_word_serializer;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data_m, in_data_l;
  logic       in_valid_m, in_valid_l;
  logic       in_ready_m, d_out_m, bit_valid_m, word_start_m, busy_m;
  logic       in_ready_l, d_out_l, bit_valid_l, word_start_l, busy_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data_m), .in_valid(in_valid_m),
    .in_ready(in_ready_m), .d_out(d_out_m), .bit_valid(bit_valid_m),
    .word_start(word_start_m), .busy(busy_m)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .d_out(d_out_l), .bit_valid(bit_valid_l),
    .word_start(word_start_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one word on the MSB-first instance; call in the cycle of its first bit.
  // seq holds the expected d_out values in emission order, seq[7] first.
  task automatic expect_word_m(input string tag, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      check({tag, " d_out"}, d_out_m, seq[7-i]);
      check({tag, " bit_valid"}, bit_valid_m, 1'b1);
      check({tag, " word_start"}, word_start_m, i == 0);
      step();
    end
    $display("word %s done", tag);
  endtask

  // Present words on the MSB instance, each held until accepted.
  task automatic drive_words_m(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [7:0] words [3];
    logic       acc;
    words[0] = w0; words[1] = w1; words[2] = w2;
    for (int w = 0; w < 3; w++) begin
      in_valid_m = 1'b1;
      in_data_m  = words[w];
      do begin
        @(negedge clk);
        acc = in_ready_m;
        step();
      end while (!acc);
    end
    in_valid_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] stream;
    logic [3:0]  hist;
    bit          found;

    reset = 1'b1;
    in_valid_m = 1'b0; in_data_m = '0;
    in_valid_l = 1'b0; in_data_l = '0;
    step();
    step();
    check("ready during reset", in_ready_m, 1'b0);
    reset = 1'b0;
    #1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      check("idle d_out", d_out_m, 1'b0);
      check("idle bit_valid", bit_valid_m, 1'b0);
      check("idle in_ready", in_ready_m, 1'b1);
      check("idle busy", busy_m, 1'b0);
      check("idle word_start", word_start_m, 1'b0);
      step();
    end
    $display("idle 20 cycles done");

    // Single word 0x96, also scanned for the detector pattern 1001
    in_valid_m = 1'b1; in_data_m = 8'h96;
    step();
    in_valid_m = 1'b0;
    hist = '0;
    for (int i = 0; i < 8; i++) begin
      hist = {hist[2:0], d_out_m};
      found = (hist == DETECT_PATTERN);
      check("0x96 pattern hit", found, i == 3);
      check("0x96 d_out", d_out_m, 8'b1001_0110 >> (7 - i) & 8'h1);
      check("0x96 word_start", word_start_m, i == 0);
      check("0x96 bit_valid", bit_valid_m, 1'b1);
      step();
    end
    check("0x96 after bit_valid", bit_valid_m, 1'b0);
    check("0x96 after d_out", d_out_m, 1'b0);
    check("0x96 after busy", busy_m, 1'b0);
    $display("word 0x96 done");
    step();

    // Back-to-back A5, 3C, FF with in_valid held high
    stream = 24'hA5_3CFF;
    fork
      drive_words_m(8'hA5, 8'h3C, 8'hFF);
      begin
        int n;
        n = 0;
        step();
        while (!bit_valid_m && n < 20) begin
          step();
          n++;
        end
        check("b2b start seen", bit_valid_m, 1'b1);
        for (int k = 0; k < 24; k++) begin
          check("b2b d_out", d_out_m, stream[23-k]);
          check("b2b bit_valid", bit_valid_m, 1'b1);
          check("b2b word_start", word_start_m, (k % 8) == 0);
          check("b2b busy", busy_m, 1'b1);
          check("b2b in_ready", in_ready_m,
                (k == 0) || (k == 8) || (k >= 16));
          step();
        end
        check("b2b end bit_valid", bit_valid_m, 1'b0);
        $display("stream A5 3C FF done");
      end
    join
    step();

    // LSB-first 0x01
    in_valid_l = 1'b1; in_data_l = 8'h01;
    step();
    in_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb d_out", d_out_l, i == 0);
      check("lsb word_start", word_start_l, i == 0);
      check("lsb bit_valid", bit_valid_l, 1'b1);
      step();
    end
    check("lsb after bit_valid", bit_valid_l, 1'b0);
    $display("word 0x01 lsb-first done");
    step();

    // Transfer on the last-bit edge with hold empty: 0x0F then 0xF0, no gap
    in_valid_m = 1'b1; in_data_m = 8'h0F;
    step();
    in_valid_m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("bypass d_out", d_out_m, 16'h0FF0 >> (15 - k) & 16'h1);
      check("bypass bit_valid", bit_valid_m, 1'b1);
      check("bypass word_start", word_start_m, (k % 8) == 0);
      check("bypass in_ready", in_ready_m, 1'b1);
      if (k == 7) begin
        in_valid_m = 1'b1; in_data_m = 8'hF0;
      end
      step();
      in_valid_m = 1'b0;
    end
    check("bypass end bit_valid", bit_valid_m, 1'b0);
    $display("words 0x0F 0xF0 bypass done");
    step();

    // Reset at bit 3 of 0x96 with the hold register full
    in_valid_m = 1'b1; in_data_m = 8'h96;
    step();
    in_data_m = 8'h55;
    step();
    in_valid_m = 1'b0;
    check("rst hold in_ready", in_ready_m, 1'b0);
    check("rst hold busy", busy_m, 1'b1);
    step();
    step();
    check("rst bit3 word_start", word_start_m, 1'b0);
    check("rst bit3 d_out", d_out_m, 1'b1);
    reset = 1'b1;
    step();
    check("rst d_out", d_out_m, 1'b0);
    check("rst bit_valid", bit_valid_m, 1'b0);
    check("rst busy", busy_m, 1'b0);
    check("rst in_ready", in_ready_m, 1'b0);
    reset = 1'b0;
    #1;
    check("post rst in_ready", in_ready_m, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("post rst no resume", bit_valid_m, 1'b0);
      check("post rst busy", busy_m, 1'b0);
      step();
    end
    in_valid_m = 1'b1; in_data_m = 8'h80;
    step();
    in_valid_m = 1'b0;
    expect_word_m("0x80", 8'b1000_0000);
    check("0x80 after bit_valid", bit_valid_m, 1'b0);
    check("0x80 after d_out", d_out_m, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
